// File: rtl/inst_queue_pkg.sv
// Shared widths, entry layout and state encodings for the fetch-to-decode instruction queue.
package inst_queue_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef logic [INST_W-1:0] inst_bus_t;
  typedef logic [ADDR_W-1:0] addr_bus_t;

  // One queued fetch result.
  typedef struct packed {
    inst_bus_t inst;
    addr_bus_t pc;
  } iq_entry_t;

  typedef enum logic {
    IqNormal = 1'b0,
    IqWaitDs = 1'b1
  } iq_state_e;

endpackage

// File: rtl/inst_queue_storage.sv
// Entry array for the instruction queue: one synchronous write port, one asynchronous read port.
// Not reset; the queue gates its outputs while empty so stale contents are never visible.
module inst_queue_storage
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  iq_entry_t        wdata,
  input  logic [PTR_W-1:0] raddr,
  output iq_entry_t        rdata
);

  iq_entry_t mem [DEPTH];

  // Write the accepted entry at the tail slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction buffer between fetch and decode_pt1: circular FIFO with flush that can keep
// exactly one branch delay-slot instruction, including one that has not arrived yet.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [INST_W-1:0] push_inst,
  input  logic [ADDR_W-1:0] push_pc,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [INST_W-1:0] pop_inst,
  output logic [ADDR_W-1:0] pop_pc,
  input  logic              flush,
  input  logic              flush_keep_ds,
  output logic [PTR_W:0]    count,
  output logic              wait_ds
);

  localparam logic [PTR_W:0]   CntFull = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CntOne  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  iq_state_e        state_q, state_d;

  logic      full, empty;
  logic      push_fire, pop_fire;
  logic      keep_exists;
  logic [PTR_W-1:0] keep_ptr;
  iq_entry_t wr_entry, rd_entry;

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);

  // Ready comes from registered occupancy only; no path from pop_ready.
  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop_valid && pop_ready;

  // Kept entry on a keep-flush: oldest entry not consumed this cycle.
  assign keep_exists = pop_fire ? (count_q > CntOne) : !empty;
  assign keep_ptr    = pop_fire ? rd_ptr_q + PtrOne : rd_ptr_q;

  assign wr_entry = '{inst: push_inst, pc: push_pc};

  inst_queue_storage #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .clk   (clk),
    .we    (push_fire),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  // Empty queue presents zeros, which decode as a harmless nop.
  assign pop_inst = empty ? '0 : rd_entry.inst;
  assign pop_pc   = empty ? '0 : rd_entry.pc;
  assign count    = count_q;
  assign wait_ds  = (state_q == IqWaitDs);

  // Next-state for pointers, occupancy and delay-slot wait; flush overrides FIFO bookkeeping.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    state_d  = state_q;

    if (pop_fire) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    if (push_fire) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    unique case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase

    unique case (state_q)
      IqNormal: begin
        if (flush && !flush_keep_ds) begin
          rd_ptr_d = wr_ptr_q;
          wr_ptr_d = wr_ptr_q;
          count_d  = '0;
        end else if (flush) begin
          if (keep_exists) begin
            rd_ptr_d = keep_ptr;
            wr_ptr_d = keep_ptr + PtrOne;
            count_d  = CntOne;
          end else if (push_fire) begin
            // Pushed entry was just written at wr_ptr_q; keep it alone.
            rd_ptr_d = wr_ptr_q;
            wr_ptr_d = wr_ptr_q + PtrOne;
            count_d  = CntOne;
          end else begin
            rd_ptr_d = wr_ptr_q;
            wr_ptr_d = wr_ptr_q;
            count_d  = '0;
            state_d  = IqWaitDs;
          end
        end
      end
      IqWaitDs: begin
        if (flush) begin
          // Queue already empty; a keep-flush keeps waiting for the delay slot.
          rd_ptr_d = wr_ptr_q;
          wr_ptr_d = wr_ptr_q;
          count_d  = '0;
          state_d  = flush_keep_ds ? IqWaitDs : IqNormal;
        end else if (push_fire) begin
          state_d = IqNormal;
        end
      end
      default: state_d = IqNormal;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IqNormal;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue with a queue-level reference model used as scoreboard.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_inst;
  logic [31:0] push_pc;
  logic        pop_valid;
  logic        pop_ready;
  logic [31:0] pop_inst;
  logic [31:0] pop_pc;
  logic        flush;
  logic        flush_keep_ds;
  logic [3:0]  count;
  logic        wait_ds;

  int checks   = 0;
  int failures = 0;

  // Reference model: queued {inst, pc} in order, plus delay-slot wait flag.
  logic [63:0] sb[$];
  bit          m_wait = 1'b0;

  inst_queue #(
    .DEPTH (8),
    .PTR_W (3)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .push_valid    (push_valid),
    .push_ready    (push_ready),
    .push_inst     (push_inst),
    .push_pc       (push_pc),
    .pop_valid     (pop_valid),
    .pop_ready     (pop_ready),
    .pop_inst      (pop_inst),
    .pop_pc        (pop_pc),
    .flush         (flush),
    .flush_keep_ds (flush_keep_ds),
    .count         (count),
    .wait_ds       (wait_ds)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, compare DUT against the model before the edge, advance model and clock.
  task automatic cycle(input bit pv, input logic [31:0] pc, input bit pr, input bit fl,
                       input bit keep);
    logic [63:0] head;
    logic [63:0] ent;
    bit          push_f;
    bit          pop_f;
    push_valid    = pv;
    push_pc       = pc;
    push_inst     = inst_of(pc);
    pop_ready     = pr;
    flush         = fl;
    flush_keep_ds = keep;
    #1;
    head = (sb.size() != 0) ? sb[0] : 64'h0;
    check("count", 64'(count), 64'(sb.size()));
    check("pop_valid", 64'(pop_valid), 64'(sb.size() != 0));
    check("pop_pc", 64'(pop_pc), 64'(head[31:0]));
    check("pop_inst", 64'(pop_inst), 64'(head[63:32]));
    check("push_ready", 64'(push_ready), 64'(sb.size() < 8));
    check("wait_ds", 64'(wait_ds), 64'(m_wait));
    push_f = pv && (sb.size() < 8);
    pop_f  = pr && (sb.size() != 0);
    ent    = {inst_of(pc), pc};
    if (fl) begin
      if (!keep) begin
        sb.delete();
        m_wait = 1'b0;
      end else if (m_wait) begin
        sb.delete();
      end else begin
        if (pop_f) void'(sb.pop_front());
        if (sb.size() != 0) begin
          head = sb[0];
          sb.delete();
          sb.push_back(head);
        end else if (push_f) begin
          sb.push_back(ent);
        end else begin
          m_wait = 1'b1;
        end
      end
    end else begin
      if (pop_f) void'(sb.pop_front());
      if (push_f) begin
        sb.push_back(ent);
        m_wait = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    resetn        = 1'b0;
    push_valid    = 1'b0;
    push_inst     = '0;
    push_pc       = '0;
    pop_ready     = 1'b0;
    flush         = 1'b0;
    flush_keep_ds = 1'b0;
    #12;
    check("rst_count", 64'(count), 64'h0);
    check("rst_pop_valid", 64'(pop_valid), 64'h0);
    check("rst_pop_pc", 64'(pop_pc), 64'h0);
    check("rst_pop_inst", 64'(pop_inst), 64'h0);
    check("rst_push_ready", 64'(push_ready), 64'h1);
    check("rst_wait_ds", 64'(wait_ds), 64'h0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full, attempt a push while full with a concurrent pop, then drain.
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h1000 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
    check("full_count", 64'(count), 64'h8);
    check("full_push_ready", 64'(push_ready), 64'h0);
    cycle(1'b1, 32'h1FF0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();
    check("drained_inst", 64'(pop_inst), 64'h0);

    // Steady streaming at occupancy 3; pointers wrap twice.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h4000 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
    for (int i = 3; i < 23; i++) begin
      cycle(1'b1, 32'h4000 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
      check("stream_count", 64'(count), 64'h3);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();

    // Flush without keep while a push is offered.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h1800 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h18F0, 1'b0, 1'b1, 1'b0);
    check("flush_count", 64'(count), 64'h0);
    idle();

    // Keep-flush with a pop in the same cycle keeps the second entry.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h2000 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h20F0, 1'b1, 1'b1, 1'b1);
    check("keep_pc", 64'(pop_pc), 64'h2004);
    check("keep_count", 64'(count), 64'h1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Keep-flush on an empty queue waits for the delay slot.
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("wait_set", 64'(wait_ds), 64'h1);
    idle();
    cycle(1'b1, 32'h3004, 1'b0, 1'b0, 1'b0);
    check("ds_count", 64'(count), 64'h1);
    check("ds_wait_clr", 64'(wait_ds), 64'h0);
    cycle(1'b1, 32'h3008, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h300C, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();

    // Keep-flush where the only entry is popped but a push arrives: the push is kept.
    cycle(1'b1, 32'h5000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h5004, 1'b1, 1'b1, 1'b1);
    check("keep_push_pc", 64'(pop_pc), 64'h5004);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();

    // Asynchronous reset between edges with six entries queued.
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'h6000 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
    push_valid = 1'b0;
    #3;
    resetn = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'h0);
    check("arst_pop_valid", 64'(pop_valid), 64'h0);
    check("arst_pop_inst", 64'(pop_inst), 64'h0);
    check("arst_pop_pc", 64'(pop_pc), 64'h0);
    sb.delete();
    m_wait = 1'b0;
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    idle();
    cycle(1'b1, 32'h7000, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
